hht_result_writer: RTL

// - Write-side counterpart of the HHT control read path. Control fetches column data
//   and v_values from memory by address; this block takes the HHT result stream and

---
 rtl/hht_pkg.sv | 6 +
 rtl/hht_sync_fifo.sv | 35 +++
 rtl/hht_result_writer.sv | 89 ++++++++
 3 files changed

// File: rtl/hht_pkg.sv
// hht_pkg: shared widths and the result-writer state encoding
package hht_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} wr_state_t;
endpackage

// File: rtl/hht_sync_fifo.sv
// hht_sync_fifo: first-word-fall-through FIFO, head visible without read latency
module hht_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_D);
    logic [DATA_W-1:0] mem [FIFO_D];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head = mem[rp[AW-1:0]];
    // pointers carry one extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    // storage needs no reset; only words behind the write pointer are ever read
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/hht_result_writer.sv
// hht_result_writer: streams csize result words into memory starting at wr_base
module hht_result_writer
    import hht_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [31:0]       csize,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    input  logic              mem_stall,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);
    wr_state_t state;
    logic [ADDR_W-1:0] base;
    logic [31:0] size, acc, idx;
    logic [DATA_W-1:0] head;
    logic full, empty, push, pop;
    assign res_ready = (state == RUN) && !full && (acc < size);
    assign push = res_valid && res_ready;
    assign pop = (state == RUN) && !empty && !mem_stall;
    hht_sync_fifo #(.DATA_W(DATA_W), .FIFO_D(FIFO_D)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .din(res_data),
        .head(head),
        .full(full),
        .empty(empty)
    );
    // block FSM with counters and registered memory-side outputs; the block ends once the strobe for the last popped word is out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            size      <= '0;
            acc       <= '0;
            idx       <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_wr <= pop;
            done   <= 1'b0;
            if (pop) begin
                mem_addr  <= base + ADDR_W'(idx);
                mem_wdata <= head;
                idx       <= idx + 1'b1;
            end
            if (push) acc <= acc + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state <= ARM;
                    busy  <= 1'b1;
                    base  <= wr_base;
                    size  <= csize;
                    acc   <= '0;
                    idx   <= '0;
                end
                ARM: if (size == 0) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= RUN;
                end
                RUN: if (mem_wr && idx == size) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
